// File: rtl/fx2_wr_arbiter_if.sv
// Handshake and pin bundle between the two word streams, the arbiter and the FX2 FIFO port.
// The arbiter itself uses the slave modport; the master modport is the environment side.
interface fx2_wr_arbiter_if;
    logic [15:0] a_data_i;
    logic        a_valid_i;
    logic        a_ready_o;
    logic [15:0] b_data_i;
    logic        b_valid_i;
    logic        b_last_i;
    logic        b_ready_o;
    logic        flush_i;
    logic        if_ready_i;
    logic [15:0] fd_o;
    logic        slwr_o;
    logic        pktend_o;
    logic        busy_o;

    modport slave (
        input  a_data_i, a_valid_i, b_data_i, b_valid_i, b_last_i,
        input  flush_i, if_ready_i,
        output a_ready_o, b_ready_o, fd_o, slwr_o, pktend_o, busy_o
    );

    modport master (
        output a_data_i, a_valid_i, b_data_i, b_valid_i, b_last_i,
        output flush_i, if_ready_i,
        input  a_ready_o, b_ready_o, fd_o, slwr_o, pktend_o, busy_o
    );
endinterface

// File: rtl/fx2_wr_arbiter.sv
// FX2 slave-FIFO write arbiter: B frames pre-empt the A stream, and short packets are committed with PKTEND.
// Define FX2_WR_ARBITER_ZLP_EN to turn a flush with nothing pending into a zero-length packet.
module fx2_wr_arbiter #(
    parameter int PKT_WORDS    = 256,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int CW           = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    fx2_wr_arbiter_if.slave bus
);
    localparam int WW = $clog2(PKT_WORDS);

    typedef enum logic [1:0] {IDLE, B_FRAME, PKTEND} state_t;

    state_t        state, state_n;
    logic [WW-1:0] word_cnt, word_cnt_n;
    logic [CW-1:0] idle_cnt, idle_cnt_n;
    logic          flush_pend, flush_pend_n;
    logic [15:0]   fd_q, fd_n;
    logic          slwr_q, slwr_n;
    logic          pktend_q, pktend_n;
    logic          pending, timeout, zlp, go;
    logic          a_acc, b_acc;

    always_comb begin
        pending = word_cnt != '0;
        timeout = idle_cnt == CW'(IDLE_TIMEOUT);
`ifdef FX2_WR_ARBITER_ZLP_EN
        zlp = flush_pend && !pending;
`else
        zlp = 1'b0;
`endif
        // Committing a packet outranks new words so a busy stream cannot starve a flush.
        go = state == IDLE && bus.if_ready_i
             && ((pending && (timeout || flush_pend)) || zlp);
        b_acc = !reset_i && bus.if_ready_i && bus.b_valid_i && !go
                && (state == IDLE || state == B_FRAME);
        a_acc = !reset_i && bus.if_ready_i && bus.a_valid_i && !bus.b_valid_i
                && !go && state == IDLE;
    end

    always_comb begin
        state_n      = state;
        word_cnt_n   = word_cnt;
        idle_cnt_n   = idle_cnt;
        flush_pend_n = flush_pend;
        fd_n         = fd_q;
        slwr_n       = a_acc || b_acc;
        pktend_n     = 1'b0;

        unique case (state)
            IDLE: begin
                if (go) begin
                    state_n = PKTEND;
                end else if (b_acc && !bus.b_last_i) begin
                    state_n = B_FRAME;
                end
            end
            B_FRAME: begin
                if (b_acc && bus.b_last_i) begin
                    state_n = IDLE;
                end
            end
            PKTEND: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (go) begin
            pktend_n     = 1'b1;
            word_cnt_n   = '0;
            idle_cnt_n   = '0;
            flush_pend_n = 1'b0;
        end else begin
            // A flush with nothing to commit is dropped unless it becomes a ZLP.
            if (state == IDLE && flush_pend && !pending && !zlp) begin
                flush_pend_n = 1'b0;
            end
            if (a_acc || b_acc) begin
                word_cnt_n = (word_cnt == WW'(PKT_WORDS - 1)) ? '0
                                                              : word_cnt + 1'b1;
                idle_cnt_n = '0;
                fd_n       = b_acc ? bus.b_data_i : bus.a_data_i;
            end else if (state == IDLE && pending && !timeout) begin
                idle_cnt_n = idle_cnt + 1'b1;
            end
        end

        if (bus.flush_i) begin
            flush_pend_n = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            word_cnt   <= '0;
            idle_cnt   <= '0;
            flush_pend <= 1'b0;
            fd_q       <= '0;
            slwr_q     <= 1'b0;
            pktend_q   <= 1'b0;
        end else begin
            state      <= state_n;
            word_cnt   <= word_cnt_n;
            idle_cnt   <= idle_cnt_n;
            flush_pend <= flush_pend_n;
            fd_q       <= fd_n;
            slwr_q     <= slwr_n;
            pktend_q   <= pktend_n;
        end
    end

    assign bus.a_ready_o = a_acc;
    assign bus.b_ready_o = b_acc;
    assign bus.fd_o      = fd_q;
    assign bus.slwr_o    = slwr_q;
    assign bus.pktend_o  = pktend_q;
    assign bus.busy_o    = pending || state == B_FRAME;
endmodule

// File: tb/tb_fx2_wr_arbiter.sv
// Bench for fx2_wr_arbiter: directed scenarios plus random traffic against a word-count reference model.
// Expectations follow FX2_WR_ARBITER_ZLP_EN when it is defined.
module tb_fx2_wr_arbiter;
    localparam int PKT = 256;
    localparam int TO  = 1024;
`ifdef FX2_WR_ARBITER_ZLP_EN
    localparam bit ZLP = 1'b1;
`else
    localparam bit ZLP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    fx2_wr_arbiter_if bus();

    fx2_wr_arbiter #(
        .PKT_WORDS   (PKT),
        .IDLE_TIMEOUT(TO),
        .CW          (16)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: packet fill, idle time, open frame, pending flush
    int          m_words, m_idle;
    bit          m_frame, m_flush, m_pkt;
    logic [15:0] m_fd;
    bit          m_slwr, m_pktend;

    // {a_ready, b_ready, fd, slwr, pktend, busy}
    logic [20:0] obs, exp_v;
    int          n_slwr, n_pkt;
    logic [15:0] seen[$];

    task automatic model_clear();
        m_words = 0; m_idle = 0; m_frame = 0; m_flush = 0; m_pkt = 0;
        m_fd = '0; m_slwr = 0; m_pktend = 0;
    endtask

    task automatic drive_idle();
        bus.a_valid_i = 0; bus.a_data_i = '0;
        bus.b_valid_i = 0; bus.b_data_i = '0; bus.b_last_i = 0;
        bus.flush_i = 0; bus.if_ready_i = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input bit av, input logic [15:0] ad,
                         input bit bv, input logic [15:0] bd, input bit bl,
                         input bit fl, input bit ir);
        bit go, acc_a, acc_b;
        bus.a_valid_i = av; bus.a_data_i = ad;
        bus.b_valid_i = bv; bus.b_data_i = bd; bus.b_last_i = bl;
        bus.flush_i = fl; bus.if_ready_i = ir;
        go = !m_frame && !m_pkt && ir
             && ((m_words != 0 && (m_idle >= TO || m_flush))
                 || (ZLP && m_flush && m_words == 0));
        acc_b = ir && bv && !m_pkt && !go;
        acc_a = ir && av && !bv && !m_pkt && !m_frame && !go;
        #1;
        obs[20:19] = {bus.a_ready_o, bus.b_ready_o};
        @(posedge clk);
        #1;
        m_slwr = acc_a || acc_b;
        m_pktend = go;
        if (acc_b) m_fd = bd;
        else if (acc_a) m_fd = ad;
        if (go) begin
            m_words = 0; m_idle = 0; m_flush = 0; m_pkt = 1;
        end else begin
            if (!m_frame && !m_pkt && m_flush && m_words == 0 && !ZLP)
                m_flush = 0;
            if (acc_a || acc_b) begin
                m_words = (m_words + 1) % PKT;
                m_idle = 0;
                if (acc_b) m_frame = !bl;
            end else if (!m_frame && !m_pkt && m_words != 0 && m_idle < TO) begin
                m_idle++;
            end
            m_pkt = 0;
        end
        if (fl) m_flush = 1;
        exp_v = {acc_a, acc_b, m_fd, m_slwr, m_pktend,
                 (m_words != 0) || m_frame};
        obs[18:0] = {bus.fd_o, bus.slwr_o, bus.pktend_o, bus.busy_o};
        if (bus.slwr_o) begin
            n_slwr++;
            seen.push_back(bus.fd_o);
        end
        if (bus.pktend_o) n_pkt++;
    endtask

    task automatic test_reset();
        #1;
        rst = 1'b1;
        bus.a_valid_i = 1; bus.b_valid_i = 1; bus.if_ready_i = 1;
        bus.a_data_i = 16'hFFFF; bus.b_data_i = 16'hFFFF;
        bus.b_last_i = 0; bus.flush_i = 0;
        #1;
        obs = {bus.a_ready_o, bus.b_ready_o, bus.fd_o,
               bus.slwr_o, bus.pktend_o, bus.busy_o};
        n_vec++;
        if (obs !== 21'h0) begin
            n_err++;
            $display("FAIL reset_state got %h want %h", obs, 21'h0);
        end
        do_reset();
    endtask

    task automatic test_single_timeout();
        int s_idx, p_idx;
        s_idx = -1; p_idx = -1;
        n_slwr = 0; n_pkt = 0; seen.delete();
        for (int i = 0; i < 1031; i++) begin
            cycle(i == 0, 16'h1234, 0, '0, 0, 0, 1);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL single c%0d got %h want %h", i, obs, exp_v);
            end
            if (bus.slwr_o) s_idx = i;
            if (bus.pktend_o) p_idx = i;
        end
        n_vec++;
        if (n_pkt !== 1 || s_idx !== 0 || p_idx - s_idx !== TO + 1) begin
            n_err++;
            $display("FAIL timeout_pktend got n=%0d gap=%0d want n=1 gap=%0d",
                     n_pkt, p_idx - s_idx, TO + 1);
        end
        n_vec++;
        if (seen.size() != 1 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_word got words=%0d busy=%b want 1 0",
                     seen.size(), bus.busy_o);
        end else if (seen[0] !== 16'h1234) begin
            n_err++;
            $display("FAIL single_data got %h want 1234", seen[0]);
        end
    endtask

    task automatic test_full_packet();
        logic [15:0] sent[$];
        logic [15:0] d;
        n_slwr = 0; n_pkt = 0; seen.delete();
        for (int i = 0; i < 258; i++) begin
            d = 16'($urandom);
            if (i < 256) sent.push_back(d);
            cycle(i < 256, d, 0, '0, 0, 0, 1);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL full_pkt c%0d got %h want %h", i, obs, exp_v);
            end
        end
        n_vec++;
        if (n_slwr !== 256 || n_pkt !== 0 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_pkt_counts got slwr=%0d pkt=%0d busy=%b want 256 0 0",
                     n_slwr, n_pkt, bus.busy_o);
        end
        n_vec++;
        if (seen != sent) begin
            n_err++;
            $display("FAIL full_pkt_data got %0d words want 256 in order",
                     seen.size());
        end
    endtask

    task automatic test_b_frame();
        logic [15:0] want[$];
        bit bv;
        n_slwr = 0; seen.delete();
        for (int i = 0; i < 30; i++) begin
            if (i >= 10 && i < 13) want.push_back(16'hB000 + 16'(i - 10));
            else want.push_back(16'h0A00 + 16'(i));
        end
        for (int i = 0; i < 30; i++) begin
            bv = i >= 10 && i < 13;
            cycle(1, 16'h0A00 + 16'(i), bv, 16'hB000 + 16'(i - 10),
                  i == 12, 0, 1);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL b_frame c%0d got %h want %h", i, obs, exp_v);
            end
            if (i >= 10 && i <= 13) begin
                n_vec++;
                if (obs[20] !== (i == 13)) begin
                    n_err++;
                    $display("FAIL b_lockout c%0d got a_ready=%b want %b",
                             i, obs[20], i == 13);
                end
            end
        end
        n_vec++;
        if (seen != want) begin
            n_err++;
            $display("FAIL b_contig got %0d words want 30 with B contiguous",
                     seen.size());
        end
    endtask

    task automatic test_stall();
        do_reset();
        n_slwr = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 16'hAAAA, 1, 16'hBBBB, 1, 0, 0);
            n_vec++;
            if (obs !== exp_v || obs[20:19] !== 2'b00) begin
                n_err++;
                $display("FAIL stall c%0d got %h want %h", i, obs, exp_v);
            end
        end
        cycle(1, 16'hAAAA, 1, 16'hBBBB, 1, 0, 1);
        n_vec++;
        if (n_slwr !== 1 || obs[20:19] !== 2'b01 || bus.fd_o !== 16'hBBBB) begin
            n_err++;
            $display("FAIL stall_release got rdy=%b fd=%h slwr_n=%0d want 01 bbbb 1",
                     obs[20:19], bus.fd_o, n_slwr);
        end
    endtask

    task automatic test_flush_frame();
        int l_idx, p_idx, k;
        do_reset();
        n_pkt = 0; l_idx = -1; p_idx = -1; k = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 16'h0100 + 16'(i), 0, '0, 0, 0, 1);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL ff_fill c%0d got %h want %h", i, obs, exp_v);
            end
        end
        for (int i = 0; i < 11; i++) begin
            cycle(i != 0 && i < 4, 16'h0200, i == 0 || i == 4,
                  (i == 4) ? 16'hBEEF : 16'hB001, i == 4, i == 0, 1);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL flush_frame c%0d got %h want %h", i, obs, exp_v);
            end
            if (bus.slwr_o && bus.fd_o == 16'hBEEF) l_idx = i;
            if (bus.pktend_o) p_idx = i;
        end
        n_vec++;
        if (n_pkt !== 1 || l_idx < 0 || p_idx !== l_idx + 1) begin
            n_err++;
            $display("FAIL flush_frame_pkt got n=%0d last=%0d pkt=%0d want n=1 pkt=last+1",
                     n_pkt, l_idx, p_idx);
        end
    endtask

    task automatic test_flush_empty();
        do_reset();
        n_pkt = 0; n_slwr = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, '0, 0, '0, 0, i == 3, 1);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL flush_empty c%0d got %h want %h", i, obs, exp_v);
            end
        end
        n_vec++;
        if (n_pkt !== int'(ZLP) || n_slwr !== 0) begin
            n_err++;
            $display("FAIL zlp got pkt=%0d slwr=%0d want %0d 0",
                     n_pkt, n_slwr, int'(ZLP));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 16'h7777, 1, 16'h5A5A, 0, 0, 1);
        end
        rst = 1'b1;
        #1;
        obs = {bus.a_ready_o, bus.b_ready_o, bus.fd_o,
               bus.slwr_o, bus.pktend_o, bus.busy_o};
        n_vec++;
        if (obs !== 21'h0) begin
            n_err++;
            $display("FAIL async_reset got %h want %h", obs, 21'h0);
        end
        do_reset();
    endtask

    task automatic test_random();
        bit av, bv, bl, fl, ir;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            av = $urandom_range(0, 3) != 0;
            bv = $urandom_range(0, 3) == 0;
            bl = $urandom_range(0, 2) == 0;
            fl = $urandom_range(0, 39) == 0;
            ir = $urandom_range(0, 4) != 0;
            cycle(av, 16'($urandom), bv, 16'($urandom), bl, fl, ir);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL random c%0d got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        drive_idle();
        model_clear();
        test_reset();
        test_single_timeout();
        test_full_packet();
        test_b_frame();
        test_stall();
        test_flush_frame();
        test_flush_empty();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
